fifo_word_packer: RTL and testbench



---
 rtl/fifo_word_packer_if.sv | 16 +
 rtl/fifo_word_packer.sv | 92 +++++++++
 tb/tb_fifo_word_packer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_if.sv
// Packed-word valid/ready stream from fifo_word_packer toward the bus/DMA stage.
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) ();
  localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
  localparam int BYTES_W   = $clog2(PACK_RATIO) + 1;

  logic [OUT_WIDTH-1:0] m_data;
  logic [BYTES_W-1:0]   m_bytes;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, m_bytes, m_valid, input  m_ready);
  modport slave  (input  m_data, m_bytes, m_valid, output m_ready);
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from the byte FIFO and packs PACK_RATIO of them per output word.
// Define PACKER_BIG_ENDIAN_EN to place the first byte in the top slot.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * PACK_RATIO
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  flush,
  fifo_word_packer_if.master    m,
  output logic                  busy
);
  localparam int CW = $clog2(PACK_RATIO) + 1;
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] FULL = CW'(PACK_RATIO);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;
  state_t state, state_nxt;

  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] coll;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] word;
  logic [CW-1:0]        coll_cnt;
  logic                 inflight;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CW-1:0]        out_bytes;
  logic                 out_valid;
  logic                 flush_pend, out_free, coll_full, part_ok, xfer;

  // Collector slots are zero past coll_cnt, so a partial word needs no masking.
  for (genvar i = 0; i < PACK_RATIO; i++) begin : g_slot
`ifdef PACKER_BIG_ENDIAN_EN
    assign word[PACK_RATIO-1-i] = coll[i];
`else
    assign word[i] = coll[i];
`endif
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    flush_pend = (state == ST_FLUSH);
    out_free   = ~out_valid | m.m_ready;
    coll_full  = (coll_cnt == FULL);
    part_ok    = flush_pend & ~inflight & (coll_cnt != '0) & ~coll_full;
    xfer       = out_free & (coll_full | part_ok);
    fifo_rd_en = reset_n & ~fifo_empty & ~flush_pend &
                 ((SW'(coll_cnt) + SW'(inflight)) < SW'(PACK_RATIO));
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_FLUSH;
      // A full collector drains first; the pending flush then sees coll_cnt=0 or a partial.
      ST_FLUSH: if (~inflight & ((coll_cnt == '0) | (part_ok & out_free))) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      coll      <= '0;
      coll_cnt  <= '0;
      inflight  <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
      out_valid <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      // xfer and a capture never coincide: full implies no read in flight,
      // and a partial transfer waits for inflight to clear.
      if (xfer) begin
        out_data  <= word;
        out_bytes <= coll_cnt;
        coll      <= '0;
        coll_cnt  <= '0;
      end else if (inflight) begin
        coll[coll_cnt[CW-2:0]] <= fifo_data;
        coll_cnt               <= coll_cnt + 1'b1;
      end
      if (xfer)           out_valid <= 1'b1;
      else if (m.m_ready) out_valid <= 1'b0;
    end

  assign m.m_data  = out_data;
  assign m.m_bytes = out_bytes;
  assign m.m_valid = out_valid;
  assign busy      = (coll_cnt != '0) | inflight | out_valid;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed + randomized bench for fifo_word_packer with a queue-based FIFO and word model.
`timescale 1ns/1ps
module tb_fifo_word_packer;
  localparam int DW = 8, PR = 4, OW = DW * PR, BW = $clog2(PR) + 1;
`ifdef PACKER_BIG_ENDIAN_EN
  localparam logic [OW-1:0] W_A = 32'h11223344, W_B = 32'h55667788, W_FL = 32'hAABBCC00;
`else
  localparam logic [OW-1:0] W_A = 32'h44332211, W_B = 32'h88776655, W_FL = 32'h00CCBBAA;
`endif
  typedef byte unsigned bq_t[$];

  logic clk = 0, reset_n = 1, fifo_empty = 1, flush = 0;
  logic fifo_rd_en, busy;
  logic [DW-1:0] fifo_data;

  fifo_word_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) mif ();
  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .flush(flush), .m(mif.master), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, pops = 0, valid_cycles = 0;
  bq_t src_q, pend;
  logic [OW-1:0] exp_d_q[$], rx_d_q[$];
  logic [BW-1:0] exp_b_q[$], rx_b_q[$];
  bit empty_gate = 0, toggle_mode = 0, rand_gate = 0;
  byte unsigned pb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack(input bq_t b);
    logic [OW-1:0] w = '0;
    for (int i = 0; i < b.size(); i++)
`ifdef PACKER_BIG_ENDIAN_EN
      w[OW-1-DW*i -: DW] = b[i];
`else
      w[DW*i +: DW] = b[i];
`endif
    return w;
  endfunction

  // FIFO read port plus word model: every PR popped bytes form a word; a flush emits the rest.
  always @(posedge clk) begin
    if (!reset_n) pend.delete();
    else begin
      if (fifo_rd_en && src_q.size() > 0) begin
        pb = src_q.pop_front();
        fifo_data <= pb;
        pend.push_back(pb);
        pops++;
        if (pend.size() == PR) begin
          exp_d_q.push_back(pack(pend)); exp_b_q.push_back(BW'(PR)); pend.delete();
        end
      end
      if (flush && pend.size() > 0) begin
        exp_d_q.push_back(pack(pend)); exp_b_q.push_back(BW'(pend.size())); pend.delete();
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (toggle_mode)    empty_gate = ~empty_gate;
    else if (rand_gate) empty_gate = ($urandom_range(0, 3) == 0);
    fifo_empty = empty_gate || (src_q.size() == 0);
  end

  logic hold_v = 0;
  logic [OW-1:0] hold_d;
  logic [BW-1:0] hold_b;
  always @(negedge clk) begin
    if (!reset_n) hold_v = 0;
    else begin
      chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
      if (hold_v) begin
        chk("hold_valid", mif.m_valid, 1);
        chk("hold_data", mif.m_data, hold_d);
        chk("hold_bytes", mif.m_bytes, hold_b);
      end
      hold_v = mif.m_valid & ~mif.m_ready;
      hold_d = mif.m_data;
      hold_b = mif.m_bytes;
      if (mif.m_valid) valid_cycles++;
      if (mif.m_valid && mif.m_ready) begin
        rx_d_q.push_back(mif.m_data); rx_b_q.push_back(mif.m_bytes);
        chk("word_expected", exp_d_q.size() != 0, 1);
        if (exp_d_q.size() != 0) begin
          chk("word_data", mif.m_data, exp_d_q.pop_front());
          chk("word_bytes", mif.m_bytes, exp_b_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy || src_q.size() != 0 || exp_d_q.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk({tag, "_timeout"}, n < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, p0, v0;
    byte unsigned bp[12];
    bq_t tmp;
    mif.m_ready = 0;
    #1 reset_n = 0;
    @(negedge clk);
    chk("rst_valid", mif.m_valid, 0);
    chk("rst_data", mif.m_data, 0);
    chk("rst_bytes", mif.m_bytes, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    step(2);
    reset_n = 1;

    // Steady stream
    mif.m_ready = 1;
    n0 = rx_d_q.size(); v0 = valid_cycles;
    foreach (W_A[i]) ;
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i * 8'h11));
    for (int i = 0; i < 4; i++) begin @(negedge clk); chk("steady_rd_en", fifo_rd_en, 1); end
    @(negedge clk); chk("steady_rd_gap", fifo_rd_en, 0);
    wait_idle(100, "steady");
    chk("steady_count", rx_d_q.size(), n0 + 2);
    chk("steady_w0", rx_d_q[n0], W_A);
    chk("steady_w1", rx_d_q[n0+1], W_B);
    chk("steady_bytes", rx_b_q[n0], PR);
    chk("steady_valid_cycles", valid_cycles - v0, 2);

    // Backpressure with 12 bytes available: only 8 may be popped
    step(1);
    mif.m_ready = 0;
    p0 = pops; n0 = rx_d_q.size();
    for (int i = 0; i < 12; i++) begin bp[i] = 8'($urandom); src_q.push_back(bp[i]); end
    step(30);
    @(negedge clk);
    chk("bp_pops", pops - p0, 8);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_valid", mif.m_valid, 1);
    step(1);
    mif.m_ready = 1;
    @(negedge clk);
    tmp = {bp[0], bp[1], bp[2], bp[3]};
    chk("bp_w0_valid", mif.m_valid, 1);
    chk("bp_w0_data", mif.m_data, pack(tmp));
    @(negedge clk);
    tmp = {bp[4], bp[5], bp[6], bp[7]};
    chk("bp_w1_valid", mif.m_valid, 1);
    chk("bp_w1_data", mif.m_data, pack(tmp));
    wait_idle(100, "bp");
    chk("bp_count", rx_d_q.size(), n0 + 3);

    // Empty flag toggling every cycle
    step(1);
    n0 = rx_d_q.size();
    toggle_mode = 1;
    for (int i = 1; i <= 4; i++) src_q.push_back(8'(i * 8'h11));
    wait_idle(100, "gate");
    toggle_mode = 0; empty_gate = 0;
    chk("gate_word", rx_d_q[n0], W_A);

    // Flush of a partial word, then flush with nothing collected
    step(1);
    n0 = rx_d_q.size();
    src_q.push_back(8'hAA); src_q.push_back(8'hBB); src_q.push_back(8'hCC);
    step(15);
    chk("flush_held", rx_d_q.size(), n0);
    flush = 1; step(1); flush = 0;
    wait_idle(100, "flush");
    chk("flush_word", rx_d_q[n0], W_FL);
    chk("flush_bytes", rx_b_q[n0], 3);
    n0 = rx_d_q.size(); v0 = valid_cycles;
    flush = 1; step(1); flush = 0;
    step(10);
    chk("flush_empty_words", rx_d_q.size(), n0);
    chk("flush_empty_valid", valid_cycles - v0, 0);
    chk("flush_empty_busy", busy, 0);

    // Asynchronous reset with two bytes collected and a third in flight
    n0 = rx_d_q.size();
    for (int i = 1; i <= 5; i++) src_q.push_back(8'(i));
    repeat (3) @(posedge clk);
    #3 reset_n = 0;
    src_q.delete();
    #1;
    chk("rstmid_valid", mif.m_valid, 0);
    chk("rstmid_rd_en", fifo_rd_en, 0);
    chk("rstmid_busy", busy, 0);
    step(2);
    reset_n = 1;
    step(1);
    chk("rstmid_idle", busy, 0);
    tmp = {};
    for (int i = 0; i < 4; i++) begin pb = 8'($urandom); tmp.push_back(pb); src_q.push_back(pb); end
    wait_idle(100, "rstmid");
    chk("rstmid_count", rx_d_q.size(), n0 + 1);
    chk("rstmid_word", rx_d_q[n0], pack(tmp));
    chk("rstmid_bytes", rx_b_q[n0], PR);

    // Randomized traffic: bursts, stalls, empty gaps and flushes
    rand_gate = 1;
    for (int c = 0; c < 400; c++) begin
      step(1);
      if (src_q.size() < 16 && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 6)) src_q.push_back(8'($urandom));
      mif.m_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
    end
    step(1);
    flush = 0; rand_gate = 0; empty_gate = 0; mif.m_ready = 1;
    for (int n = 0; n < 300 && src_q.size() != 0; n++) step(1);
    chk("rand_drained", src_q.size(), 0);
    step(3);
    flush = 1; step(1); flush = 0;
    wait_idle(300, "rand");
    chk("rand_exp_empty", exp_d_q.size(), 0);
    chk("rand_pend_empty", pend.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
